fetch_unit: RTL and testbench

Instruction-fetch stage placed directly upstream of `imem`. Holds the program counter and drives the 6-bit word address into `imem`. Registers the returned 32-bit instruction together with its PC into a fetch/decode output register for the decode stage. Supports branch redirect with flush, downstream stall, and an optional halt on the program-end marker word.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/pc_reg.sv | 21 ++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] HALT_WORD = 32'hb400001f;  // CBZ XZR, #0 program-end marker
    localparam int unsigned PC_STEP   = 4;

    typedef enum logic [0:0] {
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: N-bit, async reset to RESET_PC, load on enable.
module pc_reg #(
    parameter int unsigned     N        = 64,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_PC;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem word address and fetch/decode output register.
// Optional halt on the program-end marker when FETCH_HALT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned  N        = 64,
    parameter int unsigned  AW       = 6,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_q,
    input  logic          pc_src,
    input  logic [N-1:0]  pc_branch,
    input  logic          stall,
    output logic [31:0]   instr_o,
    output logic [N-1:0]  pc_o,
    output logic          valid_o,
    output logic          halted
);

    localparam logic [N-1:0] PC_INC = N'(PC_STEP);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;
    logic         pc_en;
    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] pc_o_q, pc_o_d;
    logic         valid_q, valid_d;
    logic         run;

    pc_reg #(
        .N        (N),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    // Low two PC bits never reach imem; high bits alias.
    assign imem_addr = pc_q[AW+1:2];

`ifdef FETCH_HALT_EN
    fetch_state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign run    = (state_q == RUN);
    assign halted = (state_q == HALT);
`else
    assign run    = 1'b1;
    assign halted = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        pc_en   = 1'b0;
        instr_d = instr_q;
        pc_o_d  = pc_o_q;
        valid_d = valid_q;
`ifdef FETCH_HALT_EN
        state_d = state_q;
`endif
        if (run) begin
            if (pc_src) begin
                // Flush the wrong-path word; redirect wins over stall.
                pc_d    = pc_branch;
                pc_en   = 1'b1;
                instr_d = '0;
                valid_d = 1'b0;
            end else if (!stall) begin
                pc_d    = pc_q + PC_INC;
                pc_en   = 1'b1;
                instr_d = imem_q;
                pc_o_d  = pc_q;
                valid_d = 1'b1;
`ifdef FETCH_HALT_EN
                if (imem_q == HALT_WORD) begin
                    state_d = HALT;
                end
`endif
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            pc_o_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_o_q  <= pc_o_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_o_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural imem model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        pc_src;
    logic [63:0] pc_branch;
    logic        stall;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        valid_o;
    logic        halted;

    logic [31:0] mem [64];
    int          n_tests;
    int          n_fail;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_q    (imem_q),
        .pc_src    (pc_src),
        .pc_branch (pc_branch),
        .stall     (stall),
        .instr_o   (instr_o),
        .pc_o      (pc_o),
        .valid_o   (valid_o),
        .halted    (halted)
    );

    assign imem_q = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0a00_0000 + i;
        mem[0]    = 32'hf8000001;
        mem[1]    = 32'hf8008002;
        mem[2]    = 32'hf8000203;
        mem[9]    = 32'h8b040064;
        mem[46]   = 32'hb400001f;
        mem[63]   = 32'h0000_0000;
        reset     = 1'b1;
        pc_src    = 1'b0;
        pc_branch = '0;
        stall     = 1'b0;

        #3;
        check_eq("rst_instr", instr_o, 0);
        check_eq("rst_pc_o", pc_o, 0);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_addr", imem_addr, 0);
        #9 reset = 1'b0;

        // Straight-line fetch from reset
        tick();
        check_eq("c1_instr", instr_o, 64'hf8000001);
        check_eq("c1_pc_o", pc_o, 0);
        check_eq("c1_valid", valid_o, 1);
        tick();
        check_eq("c2_instr", instr_o, 64'hf8008002);
        check_eq("c2_pc_o", pc_o, 4);
        tick();
        check_eq("c3_instr", instr_o, 64'hf8000203);
        check_eq("c3_pc_o", pc_o, 8);
        tick();
        check_eq("c4_pc_o", pc_o, 12);
        check_eq("c4_addr", imem_addr, 4);

        // Stall three cycles at pc 0x10
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_instr", instr_o, 64'h0a000003);
            check_eq("stall_pc_o", pc_o, 12);
            check_eq("stall_addr", imem_addr, 4);
        end
        stall = 1'b0;
        tick();
        check_eq("resume_pc_o", pc_o, 64'h10);
        check_eq("resume_instr", instr_o, 64'h0a000004);

        // Branch while stalled: redirect wins
        pc_src    = 1'b1;
        pc_branch = 64'h24;
        stall     = 1'b1;
        tick();
        check_eq("br_valid", valid_o, 0);
        check_eq("br_instr", instr_o, 0);
        check_eq("br_pc_o_hold", pc_o, 64'h10);
        check_eq("br_addr", imem_addr, 9);
        pc_src = 1'b0;
        stall  = 1'b0;
        tick();
        check_eq("tgt_instr", instr_o, 64'h8b040064);
        check_eq("tgt_pc_o", pc_o, 64'h24);
        check_eq("tgt_valid", valid_o, 1);

        // Misaligned target: low bits dropped from the address only
        pc_src    = 1'b1;
        pc_branch = 64'h27;
        tick();
        check_eq("mis_addr", imem_addr, 9);
        pc_src = 1'b0;
        tick();
        check_eq("mis_pc_o", pc_o, 64'h27);
        check_eq("mis_instr", instr_o, 64'h8b040064);
        check_eq("mis_next_addr", imem_addr, 10);

        // Async reset mid-stream at pc 0x40
        pc_src    = 1'b1;
        pc_branch = 64'h3c;
        tick();
        pc_src = 1'b0;
        tick();
        check_eq("pre_rst_pc_o", pc_o, 64'h3c);
        check_eq("pre_rst_addr", imem_addr, 16);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_instr", instr_o, 0);
        check_eq("arst_pc_o", pc_o, 0);
        check_eq("arst_valid", valid_o, 0);
        check_eq("arst_addr", imem_addr, 0);
        #2 reset = 1'b0;
        tick();
        check_eq("post_rst_instr", instr_o, 64'hf8000001);
        check_eq("post_rst_pc_o", pc_o, 0);

        // PCs beyond imem size alias
        pc_src    = 1'b1;
        pc_branch = 64'h108;
        tick();
        check_eq("alias_addr", imem_addr, 2);
        pc_src = 1'b0;
        tick();
        check_eq("alias_instr", instr_o, 64'hf8000203);
        check_eq("alias_pc_o", pc_o, 64'h108);

        // PC wrap at 2^64
        pc_src    = 1'b1;
        pc_branch = 64'hffff_ffff_ffff_fffc;
        tick();
        check_eq("wrap_addr", imem_addr, 63);
        pc_src = 1'b0;
        tick();
        check_eq("wrap_instr", instr_o, 0);
        check_eq("wrap_pc_o", pc_o, 64'hffff_ffff_ffff_fffc);
        check_eq("wrap_valid", valid_o, 1);
        check_eq("wrap_next_addr", imem_addr, 0);

        // Redirect coincident with marker fetch: flushed, no halt
        pc_src    = 1'b1;
        pc_branch = 64'hb8;
        tick();
        tick();
        check_eq("mk_flush_valid", valid_o, 0);
        check_eq("mk_flush_halted", halted, 0);
        check_eq("mk_flush_addr", imem_addr, 46);
        pc_src = 1'b0;
        tick();
        check_eq("mk_instr", instr_o, 64'hb400001f);
        check_eq("mk_pc_o", pc_o, 64'hb8);
        check_eq("mk_valid", valid_o, 1);

`ifdef FETCH_HALT_EN
        for (int i = 0; i < 10; i++) begin
            pc_src    = i[0];
            pc_branch = 64'h24;
            tick();
            check_eq("halt_halted", halted, 1);
            check_eq("halt_valid", valid_o, 0);
            check_eq("halt_addr", imem_addr, 47);
            check_eq("halt_pc_o", pc_o, 64'hb8);
            check_eq("halt_instr", instr_o, 64'hb400001f);
        end
        pc_src = 1'b0;
`else
        tick();
        check_eq("nohalt_halted", halted, 0);
        check_eq("nohalt_instr", instr_o, 64'h0a00002f);
        check_eq("nohalt_pc_o", pc_o, 64'hbc);
        check_eq("nohalt_valid", valid_o, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
